// File: rtl/fp_pkg.sv
// Shared constants and bundle types for the pipelined FP adder.
package fp_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;
  localparam int TAG_W_DEF = 4;

  localparam int FLG_INV = 2;
  localparam int FLG_OVF = 1;
  localparam int FLG_INX = 0;

  typedef struct packed {
    logic       byp;
    logic [2:0] flags;
  } byp_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; all-zero input yields W.
module fp_lzc #(
  parameter int W  = 27,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  d_i,
  output logic [CW-1:0] cnt_o
);

  logic found;

  always_comb begin
    cnt_o = '0;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (!found && !d_i[i]) cnt_o = cnt_o + CW'(1);
      else found = 1'b1;
    end
  end

endmodule

// File: rtl/fp_add_pipe.sv
// Three-stage FP add/sub: compare/swap, align+add, normalize+round (RNE).
module fp_add_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic                   in_sub,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_res,
  output logic [TAG_W-1:0]       out_tag,
  output logic [2:0]             out_flags
);

  localparam int N      = 1 + EXP_W + MAN_W;
  localparam int XW     = MAN_W + 4;
  localparam int SW     = EXP_W + 2;
  localparam int LW     = $clog2(XW + 1);
  localparam int SIGN_B = EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [N-1:0] QNAN =
    {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   man_l;
    logic [MAN_W:0]   man_s;
    logic [EXP_W-1:0] d;
    logic             eff_sub;
    byp_t             byp;
    logic [N-1:0]     res;
    logic [TAG_W-1:0] tag;
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [XW:0]      sum;
    logic             eff_sub;
    byp_t             byp;
    logic [N-1:0]     res;
    logic [TAG_W-1:0] tag;
  } s2_t;

  logic v1_q, v2_q, v3_q;
  s1_t  s1_q, s1_d;
  s2_t  s2_q, s2_d;
  logic [N-1:0]     res_q, res_d;
  logic [TAG_W-1:0] tag_q;
  logic [2:0]       flags_q, flags_d;
  logic s3_acc, adv2, s2_acc, adv1;

  assign s3_acc   = !v3_q || out_ready;
  assign adv2     = v2_q && s3_acc;
  assign s2_acc   = !v2_q || adv2;
  assign adv1     = v1_q && s2_acc;
  assign in_ready = !v1_q || adv1;

  assign out_valid = v3_q;
  assign out_res   = res_q;
  assign out_tag   = tag_q;
  assign out_flags = flags_q;

  // Stage 1: operand decode, magnitude swap, special-case bypass
  logic [N-1:0]     bx;
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb, fa_n, fb_n;
  logic az, bz, ainf, binf, anan, bnan, swap;

  assign bx = {in_b[SIGN_B] ^ in_sub, in_b[SIGN_B-1:0]};
  assign {sa, ea, fa} = in_a;
  assign {sb, eb, fb} = bx;
  assign az   = ea == '0;
  assign bz   = eb == '0;
  assign fa_n = az ? '0 : fa;
  assign fb_n = bz ? '0 : fb;
  assign ainf = ea == EXP_MAX && fa == '0;
  assign binf = eb == EXP_MAX && fb == '0;
  assign anan = ea == EXP_MAX && fa != '0;
  assign bnan = eb == EXP_MAX && fb != '0;
  assign swap = {eb, fb_n} > {ea, fa_n};

  always_comb begin
    s1_d         = '0;
    s1_d.tag     = in_tag;
    s1_d.eff_sub = sa ^ sb;
    if (swap) begin
      s1_d.sign  = sb;
      s1_d.exp   = eb;
      s1_d.man_l = {~bz, fb_n};
      s1_d.man_s = {~az, fa_n};
      s1_d.d     = eb - ea;
    end else begin
      s1_d.sign  = sa;
      s1_d.exp   = ea;
      s1_d.man_l = {~az, fa_n};
      s1_d.man_s = {~bz, fb_n};
      s1_d.d     = ea - eb;
    end
    if (anan || bnan) begin
      s1_d.byp.byp = 1'b1;
      s1_d.res     = QNAN;
    end else if (ainf && binf && (sa ^ sb)) begin
      s1_d.byp.byp            = 1'b1;
      s1_d.byp.flags[FLG_INV] = 1'b1;
      s1_d.res                = QNAN;
    end else if (ainf) begin
      s1_d.byp.byp = 1'b1;
      s1_d.res     = in_a;
    end else if (binf) begin
      s1_d.byp.byp = 1'b1;
      s1_d.res     = bx;
    end
  end

  // Stage 2: align smaller operand with sticky collection, add/sub
  logic [XW-1:0] ml, ms, sh, al;
  logic          lost;

  assign ml   = {s1_q.man_l, 3'b000};
  assign ms   = {s1_q.man_s, 3'b000};
  assign sh   = ms >> s1_q.d;
  assign lost = (sh << s1_q.d) != ms;

  always_comb begin
    if (32'(s1_q.d) >= XW - 1)
      al = {{(XW-1){1'b0}}, |s1_q.man_s};
    else
      al = {sh[XW-1:1], sh[0] | lost};
    s2_d         = '0;
    s2_d.sign    = s1_q.sign;
    s2_d.exp     = s1_q.exp;
    s2_d.eff_sub = s1_q.eff_sub;
    s2_d.byp     = s1_q.byp;
    s2_d.res     = s1_q.res;
    s2_d.tag     = s1_q.tag;
    if (s1_q.eff_sub) s2_d.sum = {1'b0, ml} - {1'b0, al};
    else              s2_d.sum = {1'b0, ml} + {1'b0, al};
  end

  // Stage 3: normalize, round to nearest even, range check
  logic [LW-1:0]    lz;
  logic [XW-1:0]    nm;
  logic [SW-1:0]    ne, re;
  logic [MAN_W+1:0] rm;
  logic [MAN_W-1:0] frac;
  logic             rnd_up;

  fp_lzc #(.W(XW), .CW(LW)) u_lzc (
    .d_i   (s2_q.sum[XW-1:0]),
    .cnt_o (lz)
  );

  always_comb begin
    if (s2_q.sum[XW]) begin
      nm = {s2_q.sum[XW:2], s2_q.sum[1] | s2_q.sum[0]};
      ne = SW'(s2_q.exp) + SW'(1);
    end else begin
      nm = s2_q.sum[XW-1:0] << lz;
      ne = SW'(s2_q.exp) - SW'(lz);
    end
    rnd_up = nm[2] & (nm[1] | nm[0] | nm[3]);
    rm     = {1'b0, nm[XW-1:3]} + (MAN_W+2)'(rnd_up);
    if (rm[MAN_W+1]) begin
      frac = rm[MAN_W:1];
      re   = ne + SW'(1);
    end else begin
      frac = rm[MAN_W-1:0];
      re   = ne;
    end
    res_d   = '0;
    flags_d = '0;
    if (s2_q.byp.byp) begin
      res_d   = s2_q.res;
      flags_d = s2_q.byp.flags;
    end else if (s2_q.sum == '0) begin
      res_d[SIGN_B] = s2_q.sign & ~s2_q.eff_sub;
    end else if (re[SW-1] || re == '0) begin
      res_d[SIGN_B]    = s2_q.sign;
      flags_d[FLG_INX] = 1'b1;
    end else if (re >= {2'b00, EXP_MAX}) begin
      res_d            = {s2_q.sign, EXP_MAX, {MAN_W{1'b0}}};
      flags_d[FLG_OVF] = 1'b1;
      flags_d[FLG_INX] = 1'b1;
    end else begin
      res_d            = {s2_q.sign, re[EXP_W-1:0], frac};
      flags_d[FLG_INX] = |nm[2:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      s1_q    <= '0;
      s2_q    <= '0;
      res_q   <= '0;
      tag_q   <= '0;
      flags_q <= '0;
    end else begin
      if (in_ready) v1_q <= in_valid;
      if (in_ready && in_valid) s1_q <= s1_d;
      if (s2_acc) v2_q <= v1_q;
      if (adv1) s2_q <= s2_d;
      if (s3_acc) v3_q <= v2_q;
      if (adv2) begin
        res_q   <= res_d;
        tag_q   <= s2_q.tag;
        flags_q <= flags_d;
      end
    end
  end

endmodule
